// File: rtl/pre_mc_filter_pkg.sv
// Shared types and constants for the pre-motion-correction filter path.
package pre_mc_filter_pkg;
  typedef enum logic [1:0] {ST_EMPTY, ST_FILL, ST_FULL} win_state_e;

  localparam int LINE_CNT_W = 16;
  localparam int OUT_W      = 32;

  function automatic int sum_w_f(input int pix_w, input int win);
    return pix_w + $clog2(win);
  endfunction
endpackage

// File: rtl/pix_delay_line.sv
// WIN-deep pixel history; entry WIN-1 is the pixel that leaves the window next.
module pix_delay_line
  import pre_mc_filter_pkg::*;
#(
  parameter int PIX_W = 16,
  parameter int WIN   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             shift_en,
  input  logic             clr,
  input  logic [PIX_W-1:0] din,
  output logic [PIX_W-1:0] oldest
);
  logic [WIN-1:0][PIX_W-1:0] hist_q, hist_d;

  always_comb begin
    hist_d = hist_q;
    if (clr)           hist_d = '0;
    else if (shift_en) hist_d = {hist_q[WIN-2:0], din};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) hist_q <= '0;
    else        hist_q <= hist_d;
  end

  assign oldest = hist_q[WIN-1];
endmodule

// File: rtl/pixel_window_accum.sv
// Per-line sliding-window horizontal pixel sum feeding the int-to-float converter.
// Build option WINDOW_MEAN_EN: output the truncated window mean instead of the raw sum.
module pixel_window_accum
  import pre_mc_filter_pkg::*;
#(
  parameter int PIX_W = 16,
  parameter int WIN   = 8,
  parameter int SUM_W = sum_w_f(PIX_W, WIN)
) (
  input  logic                  s_axi_aclk,
  input  logic                  s_axi_aresetn,
  input  logic                  pix_valid,
  input  logic [PIX_W-1:0]      pix_data,
  input  logic                  pix_last,
  output logic                  sum_valid,
  output logic [OUT_W-1:0]      sum_data,
  output logic                  sum_last,
  output logic [LINE_CNT_W-1:0] line_count
);
  localparam int FILL_W = $clog2(WIN + 1);
  localparam int LOG2_W = $clog2(WIN);

  if (SUM_W > OUT_W) begin : g_sum_w_chk
    $error("SUM_W exceeds converter input width");
  end
  if (WIN < 2 || WIN > 64) begin : g_win_chk
    $error("WIN out of range 2..64");
  end
`ifdef WINDOW_MEAN_EN
  if ((WIN & (WIN - 1)) != 0) begin : g_pow2_chk
    $error("WIN must be a power of two for the mean output");
  end
`endif

  win_state_e            state_q, state_d;
  logic [FILL_W-1:0]     fill_q, fill_d, fill_inc;
  logic [SUM_W-1:0]      acc_q, acc_d, acc_next, result;
  logic                  sum_valid_q, sum_valid_d;
  logic [OUT_W-1:0]      sum_data_q, sum_data_d;
  logic                  sum_last_q, sum_last_d;
  logic [LINE_CNT_W-1:0] line_cnt_q, line_cnt_d;
  logic [PIX_W-1:0]      oldest;

  pix_delay_line #(.PIX_W(PIX_W), .WIN(WIN)) u_hist (
    .clk     (s_axi_aclk),
    .rst_n   (s_axi_aresetn),
    .shift_en(pix_valid),
    .clr     (pix_valid & pix_last),
    .din     (pix_data),
    .oldest  (oldest)
  );

  // Intermediate acc+p may wrap SUM_W in FULL; the modular difference is still exact.
  assign acc_next = acc_q + SUM_W'(pix_data)
                  - ((state_q == ST_FULL) ? SUM_W'(oldest) : SUM_W'(0));
  assign fill_inc = fill_q + FILL_W'(1);
`ifdef WINDOW_MEAN_EN
  assign result = acc_next >> LOG2_W;
`else
  assign result = acc_next;
`endif

  // State register
  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      state_q     <= ST_EMPTY;
      fill_q      <= '0;
      acc_q       <= '0;
      sum_valid_q <= 1'b0;
      sum_data_q  <= '0;
      sum_last_q  <= 1'b0;
      line_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      fill_q      <= fill_d;
      acc_q       <= acc_d;
      sum_valid_q <= sum_valid_d;
      sum_data_q  <= sum_data_d;
      sum_last_q  <= sum_last_d;
      line_cnt_q  <= line_cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    acc_d   = acc_q;
    if (pix_valid) begin
      if (pix_last) begin
        state_d = ST_EMPTY;
        fill_d  = '0;
        acc_d   = '0;
      end else begin
        acc_d = acc_next;
        case (state_q)
          ST_EMPTY, ST_FILL: begin
            fill_d  = fill_inc;
            state_d = (fill_inc == FILL_W'(WIN)) ? ST_FULL : ST_FILL;
          end
          default: state_d = ST_FULL;
        endcase
      end
    end
  end

  // Output logic
  always_comb begin
    sum_valid_d = 1'b0;
    sum_data_d  = sum_data_q;
    sum_last_d  = sum_last_q;
    line_cnt_d  = line_cnt_q;
    if (pix_valid) begin
      sum_valid_d = 1'b1;
      sum_data_d  = OUT_W'(result);
      sum_last_d  = pix_last;
      if (pix_last) line_cnt_d = line_cnt_q + LINE_CNT_W'(1);
    end
  end

  assign sum_valid  = sum_valid_q;
  assign sum_data   = sum_data_q;
  assign sum_last   = sum_last_q;
  assign line_count = line_cnt_q;
endmodule

// File: tb/tb_pixel_window_accum.sv
// Bench for pixel_window_accum (WIN=4): directed vectors plus random lines vs a queue model.
module tb_pixel_window_accum;
  localparam int PIX_W = 16;
  localparam int WIN   = 4;

  logic        clk = 1'b0;
  logic        rstn;
  logic        pix_valid, pix_last;
  logic [15:0] pix_data;
  logic        sum_valid, sum_last;
  logic [31:0] sum_data;
  logic [15:0] line_count;

  int tests = 0, fails = 0;

  // reference model state
  int unsigned line_q[$];
  bit          ev, el;
  logic [31:0] ed;
  logic [15:0] lc;

  pixel_window_accum #(.PIX_W(PIX_W), .WIN(WIN)) dut (
    .s_axi_aclk   (clk),
    .s_axi_aresetn(rstn),
    .pix_valid    (pix_valid),
    .pix_data     (pix_data),
    .pix_last     (pix_last),
    .sum_valid    (sum_valid),
    .sum_data     (sum_data),
    .sum_last     (sum_last),
    .line_count   (line_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model(input bit rst, input bit v, input logic [15:0] p, input bit l);
    int unsigned s;
    int n;
    if (rst) begin
      line_q.delete(); lc = 0; ev = 0; ed = 0; el = 0;
    end else if (v) begin
      line_q.push_back(p);
      s = 0;
      n = line_q.size();
      for (int i = (n > WIN ? n - WIN : 0); i < n; i++) s += line_q[i];
`ifdef WINDOW_MEAN_EN
      ed = s / WIN;
`else
      ed = s;
`endif
      ev = 1; el = l;
      if (l) begin line_q.delete(); lc++; end
    end else ev = 0;
  endtask

  task automatic step(input bit rst, input bit v, input logic [15:0] p, input bit l);
    @(negedge clk);
    rstn = ~rst; pix_valid = v; pix_data = p; pix_last = l;
    @(posedge clk);
    #1;
    model(rst, v, p, l);
    chk("sum_valid", 32'(sum_valid), 32'(ev));
    chk("sum_data", sum_data, ed);
    chk("sum_last", 32'(sum_last), 32'(el));
    chk("line_count", 32'(line_count), 32'(lc));
  endtask

  initial begin
    int unsigned basic_exp[6];
    int unsigned gap_exp[5];
    int unsigned mean_exp[5];
    int unsigned mean_in[5];
    basic_exp = '{1, 3, 6, 10, 14, 18};
    gap_exp   = '{32'hFFFF, 32'h1FFFE, 32'h2FFFD, 32'h3FFFC, 32'h3FFFC};
    mean_in   = '{4, 4, 4, 4, 8};
`ifdef WINDOW_MEAN_EN
    mean_exp  = '{1, 2, 3, 4, 5};
`else
    mean_exp  = '{4, 8, 12, 16, 20};
`endif
    rstn = 1'b0; pix_valid = 1'b0; pix_data = '0; pix_last = 1'b0;
    lc = 0; ev = 0; ed = 0; el = 0;

    // reset held with valid input
    for (int i = 0; i < 3; i++) step(1, 1, 16'h1234, 0);

    // basic line
    for (int i = 0; i < 6; i++) begin
      step(0, 1, 16'(i + 1), i == 5);
`ifndef WINDOW_MEAN_EN
      chk("basic_lit", sum_data, basic_exp[i]);
`endif
    end
    chk("basic_lc", 32'(line_count), 1);

    // line separation
    step(0, 1, 10, 0);
    step(0, 1, 10, 1);
    chk("sep_lc", 32'(line_count), 2);
    step(0, 0, 0, 1);   // pix_last without valid is ignored
    chk("ign_lc", 32'(line_count), 2);

    // gaps and extremes
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 16'hFFFF, 0);
`ifndef WINDOW_MEAN_EN
      chk("gap_lit", sum_data, gap_exp[i]);
`endif
      step(0, 0, 16'h0, 0);
    end

    // reset mid-line
    for (int i = 0; i < 3; i++) step(0, 1, 5, 0);
    step(1, 0, 0, 0);
    step(0, 1, 7, 0);
`ifndef WINDOW_MEAN_EN
    chk("mid_rst_lit", sum_data, 7);
`endif
    chk("mid_rst_lc", 32'(line_count), 0);

    // mean vector (raw sums in default build)
    step(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 16'(mean_in[i]), 0);
      chk("mean_lit", sum_data, mean_exp[i]);
    end
    step(0, 1, 1, 1);

    // random lines with gaps, extremes and occasional reset
    for (int i = 0; i < 1500; i++) begin
      bit r, v, l;
      logic [15:0] p;
      r = ($urandom_range(0, 199) == 0);
      v = ($urandom_range(0, 3) != 0);
      l = ($urandom_range(0, 9) == 0);
      p = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      step(r, v, p, l);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pixel_window_accum.md
Name: pixel_window_accum

Overview:
- Upstream stage of the integer-to-float converter in the pre-motion-correction filter path.
- Takes an unsigned pixel stream, one pixel per valid cycle, with end-of-line markers.
- Produces a per-line sliding-window horizontal sum as a 32-bit unsigned integer, one result per input pixel.
- The result feeds the converter's int_data input directly. There is no backpressure, matching the converter, which samples every cycle.

Parameters:
- PIX_W, 16: pixel width in bits, unsigned.
- WIN, 8: window length in pixels. Legal range 2..64. Must be a power of two when WINDOW_MEAN_EN is defined.
- SUM_W, PIX_W+$clog2(WIN): internal accumulator width. Elaboration fails if SUM_W > 32.

Ports:
- s_axi_aclk, in, 1: sole clock.
- s_axi_aresetn, in, 1: reset, synchronous, active-low.
- pix_valid, in, 1: pix_data and pix_last are valid this cycle.
- pix_data, in, PIX_W: unsigned pixel value.
- pix_last, in, 1: this pixel is the last of its line. Qualified by pix_valid.
- sum_valid, out, 1: sum_data is valid. Single-cycle pulse per accepted pixel.
- sum_data, out, 32: window result, zero-extended from SUM_W. Goes to the converter's int_data.
- sum_last, out, 1: result belongs to the last pixel of a line.
- line_count, out, 16: number of completed lines since reset. Wraps 0xFFFF -> 0.

Behaviour:
- Interface: one clock, s_axi_aclk. Reset s_axi_aresetn is synchronous and active-low.
- Reset state:
  - sum_valid=0, sum_data=0, sum_last=0, line_count=0.
  - History cleared, fill counter 0, FSM in EMPTY.
- History: delay line of WIN entries, each PIX_W wide. Running accumulator acc, SUM_W bits.
- Per accepted pixel p (pix_valid=1):
  - acc_next = acc + p - oldest.
  - oldest = entry leaving the delay line when the window is FULL, otherwise 0.
- Window contents: start of line is zero-padded. Output k of a line (k from 0) is the sum of pixels max(0,k-WIN+1)..k of that line.
- Latency: registered. sum_valid/sum_data/sum_last assert exactly 1 cycle after the accepting cycle.
- No accepting cycle: sum_valid=0; sum_data and sum_last hold their last values.
- FSM states:
  - EMPTY: fill=0, no pixels in the current line.
  - FILL: 0<fill<WIN.
  - FULL: fill=WIN, subtraction active.
- Transitions, on an accepted pixel with pix_last=0:
  - EMPTY->FILL. If WIN reached on this pixel, go to FULL instead.
  - FILL->FILL, or FILL->FULL when fill+1==WIN.
  - FULL->FULL.
- pix_valid && pix_last, from any state:
  - The pixel is included in the result and sum_last=1 on that result.
  - Next state is EMPTY; acc, fill and history clear in the same edge.
  - line_count increments.
- pix_last with pix_valid=0: ignored.
- Idle cycles (pix_valid=0) inside a line: no state change; the window spans the gap.
- Arithmetic:
  - Unsigned throughout; acc never exceeds WIN*(2^PIX_W-1), so no saturation is needed.
  - sum_data[31:SUM_W]=0.
- Line of a single pixel (pix_last on the first pixel): result = that pixel, sum_last=1.
- Reset mid-line: all state discarded. The next pixel starts a new line with zero history, and line_count=0.
- Back-to-back full-rate input (pix_valid every cycle) is sustained indefinitely with no bubbles.

Optional Feature:
- Macro: WINDOW_MEAN_EN.
- Defined: sum_data = acc >> $clog2(WIN), zero-extended to 32. This is the window mean, truncated. Zero-padded partial windows at line start are still divided by WIN. WIN must be a power of two.
- Undefined: sum_data = raw acc. WIN may be any legal value.
- Latency and handshake are identical in both cases.

Decomposition:
- Shared package pre_mc_filter_pkg:
  - FSM state enum (EMPTY, FILL, FULL).
  - LINE_CNT_W=16.
  - Output width constant 32.
  - Helper function for SUM_W.
- Sub-module pix_delay_line:
  - WIN-deep, PIX_W-wide shift register with shift enable and synchronous clear.
  - Exposes the oldest entry.
- Top level holds the FSM, fill counter, accumulator, output registers and line counter.

Test Plan (WIN=4, PIX_W=16 unless noted):
- Reset check: hold s_axi_aresetn=0 for 3 cycles with pix_valid=1 -> sum_valid=0, sum_data=0, line_count=0 throughout.
- Basic line: pixels 1,2,3,4,5,6 back-to-back, pix_last on 6 -> sums 1,3,6,10,14,18, each 1 cycle after input; sum_last only with 18; line_count=1.
- Line separation: after the previous line, send 10,10 with pix_last on the second -> sums 10,20 (no carry-over); line_count=2.
- Gaps and extremes: 0xFFFF x5 with idle cycles between each -> sums 0xFFFF, 0x1FFFE, 0x2FFFD, 0x3FFFC, 0x3FFFC; sum_valid pulses only after the accepted cycles.
- Reset mid-line: send 5,5,5, pulse reset 1 cycle, then send 7 -> sum 7, line_count=0.
- WINDOW_MEAN_EN defined: 4,4,4,4,8 -> sums 1,2,3,4,5.
